// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared constants, state encoding and address helper for the kernel weight fetch controller.
// Optional kernel-sum output is enabled with WFETCH_SUM_EN.
package weight_fetch_ctrl_pkg;

    localparam int unsigned KSIZE       = 9;
    localparam int unsigned NUM_KERNELS = 3;
    localparam int unsigned BASE_ADDR   = 0;
    localparam int unsigned AW          = 8;
    localparam int unsigned DW          = 8;
    localparam int unsigned KW          = KSIZE * DW;
    localparam int unsigned CW          = $clog2(KSIZE);
    localparam int unsigned SW          = DW + 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    function automatic logic [AW-1:0] kernel_base(input logic [1:0] idx);
        return AW'(BASE_ADDR + 32'(idx) * KSIZE);
    endfunction

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Control, ROM read and kernel-stream signals of the weight fetch controller.
// kern_sum exists only when WFETCH_SUM_EN is defined.
interface weight_fetch_ctrl_if;
    import weight_fetch_ctrl_pkg::*;

    logic          start;
    logic [1:0]    kernel_idx;
    logic          busy;
    logic          idx_err;
    logic [AW-1:0] rom_addr;
    logic          rom_en;
    logic [DW-1:0] rom_data;
    logic [KW-1:0] kern_data;
    logic          kern_valid;
    logic          kern_ready;
`ifdef WFETCH_SUM_EN
    logic [SW-1:0] kern_sum;
`endif

    modport master (
        input  start, kernel_idx, rom_data, kern_ready,
`ifdef WFETCH_SUM_EN
        output kern_sum,
`endif
        output busy, idx_err, rom_addr, rom_en, kern_data, kern_valid
    );

    modport slave (
        output start, kernel_idx, rom_data, kern_ready,
`ifdef WFETCH_SUM_EN
        input  kern_sum,
`endif
        input  busy, idx_err, rom_addr, rom_en, kern_data, kern_valid
    );

endinterface

// File: rtl/weight_pack_reg.sv
// Byte-slot register: writes din into slot sel when load is set; clr zeroes every slot.
module weight_pack_reg #(
    parameter int unsigned Slots = 9,
    parameter int unsigned Width = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     load,
    input  logic [$clog2(Slots)-1:0] sel,
    input  logic [Width-1:0]         din,
    output logic [Slots*Width-1:0]   data
);

    always_ff @(posedge clk) begin
        if (clr) begin
            data <= '0;
        end else if (load) begin
            data[sel*Width +: Width] <= din;
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Fetches one kernel of KSIZE weights from the combinational weight ROM and offers it as one vector.
// Define WFETCH_SUM_EN to add the kern_sum accumulator output.
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    weight_fetch_ctrl_if.master bus
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          en_q, en_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          accept;
    logic          load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        en_d    = en_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (32'(bus.kernel_idx) < NUM_KERNELS) begin
                        accept  = 1'b1;
                        state_d = StFetch;
                        addr_d  = kernel_base(bus.kernel_idx);
                        en_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                // ROM is combinational: the word for addr_q is present at this edge.
                load   = 1'b1;
                addr_d = addr_q + AW'(1);
                if (cnt_q == CW'(KSIZE - 1)) begin
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StHold: begin
                if (bus.kern_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Slots are cleared when a fetch starts so an aborted fetch leaves no stale mix behind.
    weight_pack_reg #(
        .Slots(KSIZE),
        .Width(DW)
    ) u_pack (
        .clk (clk),
        .clr (!rst || accept),
        .load(load),
        .sel (cnt_q),
        .din (bus.rom_data),
        .data(bus.kern_data)
    );

`ifdef WFETCH_SUM_EN
    logic [SW-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (load) begin
            sum_q <= sum_q + SW'(bus.rom_data);
        end
    end

    assign bus.kern_sum = sum_q;
`endif

    assign bus.rom_addr   = addr_q;
    assign bus.rom_en     = en_q;
    assign bus.kern_valid = valid_q;
    assign bus.idx_err    = err_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl; expected vectors and sums come from a ROM array model.
// Also builds with WFETCH_SUM_EN defined, in which case kern_sum is checked.
module tb_weight_fetch_ctrl;
    import weight_fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    weight_fetch_ctrl_if bus ();

    weight_fetch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] rom [256];
    // Disabled ROM drives a sentinel so any sampling outside FETCH corrupts the vector.
    assign bus.rom_data = bus.rom_en ? rom[bus.rom_addr] : 8'hEE;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] model_vec(input int k);
        logic [KW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(KSIZE); i++) v[i*DW +: DW] = rom[int'(BASE_ADDR) + k*int'(KSIZE) + i];
        return v;
    endfunction

    function automatic int model_sum(input int k);
        int s;
        s = 0;
        for (int i = 0; i < int'(KSIZE); i++) s += int'(rom[int'(BASE_ADDR) + k*int'(KSIZE) + i]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int k, input int stall);
        logic [KW-1:0] exp_v;
        int en_cycles;
        int edges;
        exp_v     = model_vec(k);
        en_cycles = 0;
        edges     = 0;
        bus.start      = 1'b1;
        bus.kernel_idx = 2'(k);
        step();
        bus.start = 1'b0;
        check("accept_busy", bus.busy, 1);
        while (!bus.kern_valid && edges < 12) begin
            if (bus.rom_en) begin
                check("rom_addr", bus.rom_addr, int'(BASE_ADDR) + k*int'(KSIZE) + en_cycles);
                en_cycles++;
            end
            step();
            edges++;
        end
        check("valid_latency", edges, KSIZE);
        check("rom_en_cycles", en_cycles, KSIZE);
        check("kern_data", bus.kern_data, exp_v);
        check("rom_en_off_hold", bus.rom_en, 0);
`ifdef WFETCH_SUM_EN
        check("kern_sum", bus.kern_sum, model_sum(k));
`endif
        for (int s = 0; s < stall; s++) begin
            bus.kern_ready = 1'b0;
            bus.start      = (s == 0);
            bus.kernel_idx = 2'($urandom_range(0, 2));
            step();
            check("hold_valid", bus.kern_valid, 1);
            check("hold_data", bus.kern_data, exp_v);
            check("hold_busy", bus.busy, 1);
        end
        bus.start      = 1'b0;
        bus.kern_ready = 1'b1;
        step();
        bus.kern_ready = 1'b0;
        check("handshake_valid", bus.kern_valid, 0);
        check("handshake_idle", bus.busy, 0);
        check("data_kept", bus.kern_data, exp_v);
    endtask

    task automatic bad_index();
        bus.start      = 1'b1;
        bus.kernel_idx = 2'd3;
        step();
        bus.start = 1'b0;
        check("idx_err_pulse", bus.idx_err, 1);
        check("idx_err_rom_en", bus.rom_en, 0);
        check("idx_err_busy", bus.busy, 0);
        step();
        check("idx_err_clear", bus.idx_err, 0);
        check("idx_err_no_fetch", bus.rom_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] words [27];
        logic [KW-1:0] got [$];
        int acc_edge;
        int k;

        words = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h10, 8'h10, 8'h20, 8'h30,
                  8'h10, 8'h20, 8'h10, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h10,
                  8'h00, 8'h08, 8'h08, 8'h10, 8'h00, 8'h08, 8'h08, 8'h10, 8'h00};
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 27; i++) rom[int'(BASE_ADDR) + i] = words[i];

        bus.start      = 1'b0;
        bus.kernel_idx = 2'd0;
        bus.kern_ready = 1'b0;
        rst            = 1'b0;
        step();
        step();
        check("rst_rom_en", bus.rom_en, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_kern_data", bus.kern_data, 0);
        check("rst_kern_valid", bus.kern_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_idx_err", bus.idx_err, 0);
`ifdef WFETCH_SUM_EN
        check("rst_kern_sum", bus.kern_sum, 0);
`endif
        rst = 1'b1;
        step();

        // Kernel 0 with 5 cycles of backpressure.
        fetch(0, 5);
        check("k0_vector", bus.kern_data, 72'h302010102010302010);
`ifdef WFETCH_SUM_EN
        check("k0_sum", bus.kern_sum, 12'h100);
`endif
        fetch(2, 0);
        check("k2_vector", bus.kern_data, 72'h001008080010080800);
`ifdef WFETCH_SUM_EN
        check("k2_sum", bus.kern_sum, 12'h040);
`endif
        bad_index();

        // Reset while cnt=4 aborts the fetch.
        bus.start      = 1'b1;
        bus.kernel_idx = 2'd0;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_busy", bus.busy, 0);
        check("abort_rom_en", bus.rom_en, 0);
        check("abort_valid", bus.kern_valid, 0);
        check("abort_addr", bus.rom_addr, 0);
        check("abort_data", bus.kern_data, 0);
        repeat (12) step();
        check("abort_no_valid", bus.kern_valid, 0);
        fetch(1, 1);
        check("k1_vector", bus.kern_data, 72'h102010302010102010);

        // Back-to-back with ready tied high.
        bus.kern_ready = 1'b1;
        bus.start      = 1'b1;
        bus.kernel_idx = 2'd0;
        step();
        bus.kernel_idx = 2'd1;
        acc_edge = 0;
        for (int e = 1; e <= 24; e++) begin
            if (bus.kern_valid) got.push_back(bus.kern_data);
            step();
            if (acc_edge == 0 && bus.rom_en && bus.rom_addr == AW'(BASE_ADDR + KSIZE)) begin
                acc_edge  = e;
                bus.start = 1'b0;
            end
        end
        bus.start      = 1'b0;
        bus.kern_ready = 1'b0;
        check("b2b_accept_edge", acc_edge, 11);
        check("b2b_count", got.size(), 2);
        check("b2b_vec0", got.size() > 0 ? got[0] : 'x, model_vec(0));
        check("b2b_vec1", got.size() > 1 ? got[1] : 'x, model_vec(1));
        check("b2b_idle", bus.busy, 0);

        // Random ROM contents, kernels and stalls.
        for (int i = 0; i < 27; i++) rom[int'(BASE_ADDR) + i] = 8'($urandom);
        for (int r = 0; r < 12; r++) begin
            k = int'($urandom_range(0, 3));
            if (k >= int'(NUM_KERNELS)) bad_index();
            else fetch(k, int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Read-side initiator for the kernel weight ROM (8-bit address, read-enable, 8-bit data, combinational read, tri-state when disabled).
- On a start request, issues KSIZE sequential reads for the selected kernel and packs the bytes into one kernel vector.
- Presents the vector to the convolution PE array over a valid/ready handshake.
- Sits between the layer controller and the PE array; the ROM is its only data source.

Parameters:
- KSIZE, 9, weights per kernel (3x3).
- NUM_KERNELS, 3, kernels stored in ROM.
- BASE_ADDR, 0, ROM address of weight 0 of kernel 0.
- AW, 8, ROM address width.
- DW, 8, weight width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  fetch request; sampled only in IDLE.
- kernel_idx  in  2  kernel to fetch; sampled with start.
- busy  out  1  high in FETCH and HOLD.
- idx_err  out  1  one-cycle pulse when an out-of-range kernel_idx is rejected.
- rom_addr  out  AW  ROM address.
- rom_en  out  1  ROM read enable.
- rom_data  in  DW  ROM read data.
- kern_data  out  KSIZE*DW  packed kernel; weight i sits at bits [DW*i+DW-1 : DW*i].
- kern_valid  out  1  kern_data is valid.
- kern_ready  in  1  consumer accepts.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; rom_en=0, rom_addr=0, kern_data=0, kern_valid=0, busy=0, idx_err=0, counter=0.
- Reset mid-fetch or in HOLD aborts immediately; no partial vector is presented.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - start=1 and kernel_idx<NUM_KERNELS: go to FETCH; rom_addr <= BASE_ADDR + kernel_idx*KSIZE; rom_en <= 1; cnt <= 0.
  - start=1 and kernel_idx>=NUM_KERNELS: stay in IDLE; idx_err=1 for one cycle; no ROM access.
- FETCH (one word per cycle):
  - The ROM is combinational, so each edge in FETCH captures rom_data into slot cnt.
  - Each edge also increments rom_addr and cnt.
  - On the edge where cnt==KSIZE-1: rom_en <= 0; kern_valid <= 1; go to HOLD.
- HOLD:
  - kern_data is stable while kern_valid=1.
  - kern_valid=1 and kern_ready=1 at an edge: kern_valid <= 0; return to IDLE.
- Latency: start accepted at edge E0. Reads occupy the cycles after E0 through E8; kern_valid rises after E9. With ready held high, the next start is accepted 11 edges after the previous one.
- start outside IDLE is ignored (not queued).
- kern_ready while kern_valid=0 is ignored.
- rom_en=0 in IDLE and HOLD, so the ROM output stays high-Z; rom_data is never sampled then.
- Address arithmetic is AW bits wide. BASE_ADDR + NUM_KERNELS*KSIZE <= 2^AW is required; the block does not check it.
- kern_data is not cleared after a handshake; it holds until the next fetch overwrites it.

Optional Feature:
- Macro: WFETCH_SUM_EN.
- Defined:
  - Adds output kern_sum (DW+4 bits): unsigned sum of the KSIZE weights, accumulated during FETCH.
  - kern_sum is cleared on entry to FETCH, is valid with kern_valid, and resets to 0.
  - Used by the PE for normalisation.
- Undefined: no kern_sum port and no accumulator logic.

Decomposition:
- Shared package: state encoding (IDLE/FETCH/HOLD), KSIZE, DW, AW, NUM_KERNELS, BASE_ADDR defaults, and the kernel-vector width constant.
- One natural sub-module, weight_pack_reg: indexed byte-slot register with load enable, slot select and clear.

Test Plan:
- Kernel 0 (ROM words 0-8 = 10,20,30,10,20,10,10,20,30): rom_addr sequence 0..8 with rom_en=1 for exactly 9 cycles; kern_data=72'h302010102010302010; kern_valid after edge 9; kern_sum=12'h100 with WFETCH_SUM_EN.
- Kernel 2 (words 18-26): kern_data=72'h001008080010080800; kern_sum=12'h040.
- Backpressure: kern_ready=0 for 5 cycles in HOLD. kern_valid and kern_data stay stable, start is ignored, and the handshake completes on the first ready=1 edge.
- kernel_idx=3 with start: one-cycle idx_err, rom_en stays 0, busy stays 0.
- rst=0 asserted while cnt=4: the next edge gives IDLE, rom_en=0, kern_valid=0. A new fetch of kernel 1 then yields 72'h102010302010102010.
- Back-to-back: ready tied high, two consecutive starts for kernels 0 and 1 produce both vectors, with the second start accepted 11 edges after the first.
